// File: rtl/issue_select_if.sv
// Issue/squash handshake bundle between the RS slots, the select stage and the ALU.
interface issue_select_if #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS)
);
  logic                 flush;
  logic [NUM_SLOTS-1:0] slot_ready;
  logic [NUM_SLOTS-1:0] slot_pred_valid;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [IDX_W-1:0]     issue_slot;
  logic                 squash_valid;
  logic [IDX_W-1:0]     squash_slot;
  logic [NUM_SLOTS-1:0] slot_ack;
  logic [NUM_SLOTS-1:0] done_mask;
  logic                 busy;

  // Select stage side
  modport master (
    input  flush, slot_ready, slot_pred_valid, issue_ready,
    output issue_valid, issue_slot, squash_valid, squash_slot,
           slot_ack, done_mask, busy
  );

  // RS slots / ALU side
  modport slave (
    output flush, slot_ready, slot_pred_valid, issue_ready,
    input  issue_valid, issue_slot, squash_valid, squash_slot,
           slot_ack, done_mask, busy
  );
endinterface

// File: rtl/issue_select.sv
// Wakeup/select stage: round-robin issue of one predicate-true slot per cycle
// to the ALU, plus lowest-index retirement of one predicate-false slot per cycle.
module issue_select #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_SLOTS)
) (
  input logic          clk,
  input logic          rst,
  issue_select_if.master bus
);

  logic                 issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]     issue_slot_q, issue_slot_d;
  logic                 squash_valid_q, squash_valid_d;
  logic [IDX_W-1:0]     squash_slot_q, squash_slot_d;
  logic [NUM_SLOTS-1:0] done_mask_q, done_mask_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_SLOTS-1:0] issue_elig;
  logic [NUM_SLOTS-1:0] squash_elig;
  logic                 issue_found;
  logic [IDX_W-1:0]     issue_sel;
  logic [IDX_W-1:0]     rr_idx;
  logic                 squash_found;
  logic [IDX_W-1:0]     squash_sel;
  logic                 issue_free;
  logic [NUM_SLOTS-1:0] slot_ack;

  // Per-slot eligibility; predicate splits ready slots into issue vs squash
  always_comb begin
    issue_elig  = bus.slot_ready &  bus.slot_pred_valid & ~done_mask_q;
    squash_elig = bus.slot_ready & ~bus.slot_pred_valid & ~done_mask_q;
  end

  // Round-robin pick: first issue-eligible slot at or above rr_ptr, wrapping
  always_comb begin
    issue_found = 1'b0;
    issue_sel   = '0;
    rr_idx      = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      rr_idx = rr_ptr_q + IDX_W'(i);
      if (!issue_found && issue_elig[rr_idx]) begin
        issue_found = 1'b1;
        issue_sel   = rr_idx;
      end
    end
  end

  // Fixed-priority pick: lowest-index squash-eligible slot
  always_comb begin
    squash_found = 1'b0;
    squash_sel   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!squash_found && squash_elig[i]) begin
        squash_found = 1'b1;
        squash_sel   = IDX_W'(i);
      end
    end
  end

  // Next-state for the issue register, squash register, done mask and pointer
  always_comb begin
    issue_valid_d  = issue_valid_q;
    issue_slot_d   = issue_slot_q;
    squash_valid_d = squash_valid_q;
    squash_slot_d  = squash_slot_q;
    done_mask_d    = done_mask_q;
    rr_ptr_d       = rr_ptr_q;
    issue_free     = !issue_valid_q || bus.issue_ready;

    if (bus.flush) begin
      issue_valid_d  = 1'b0;
      issue_slot_d   = '0;
      squash_valid_d = 1'b0;
      squash_slot_d  = '0;
      done_mask_d    = '0;
      rr_ptr_d       = '0;
    end else begin
      if (issue_free) begin
        issue_valid_d = issue_found;
        if (issue_found) begin
          issue_slot_d           = issue_sel;
          done_mask_d[issue_sel] = 1'b1;
          // NUM_SLOTS is a power of two, so the increment wraps N-1 -> 0
          rr_ptr_d               = issue_sel + IDX_W'(1);
        end
      end
      squash_valid_d = squash_found;
      if (squash_found) begin
        squash_slot_d           = squash_sel;
        done_mask_d[squash_sel] = 1'b1;
      end
    end
  end

  // Slot-free acknowledge: issue handshake and squash pulse, suppressed by flush
  always_comb begin
    slot_ack = '0;
    if (!bus.flush) begin
      if (issue_valid_q && bus.issue_ready) slot_ack[issue_slot_q] = 1'b1;
      if (squash_valid_q)                   slot_ack[squash_slot_q] = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_q  <= 1'b0;
      issue_slot_q   <= '0;
      squash_valid_q <= 1'b0;
      squash_slot_q  <= '0;
      done_mask_q    <= '0;
      rr_ptr_q       <= '0;
    end else begin
      issue_valid_q  <= issue_valid_d;
      issue_slot_q   <= issue_slot_d;
      squash_valid_q <= squash_valid_d;
      squash_slot_q  <= squash_slot_d;
      done_mask_q    <= done_mask_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign bus.issue_valid  = issue_valid_q;
  assign bus.issue_slot   = issue_slot_q;
  assign bus.squash_valid = squash_valid_q;
  assign bus.squash_slot  = squash_slot_q;
  assign bus.done_mask    = done_mask_q;
  assign bus.slot_ack     = slot_ack;
  assign bus.busy         = issue_valid_q | squash_valid_q;

endmodule

// File: doc/issue_select.md
# issue_select

Per-frame instruction wakeup/select stage directly downstream of the reservation-station slots and their predicate handlers. Each cycle it examines every slot's operand-ready flag and predicate outcome. It picks one fireable instruction round-robin and presents it to the ALU through a valid/ready handshake. In parallel it retires one nullified (predicate-false) instruction without issuing it. It tracks which slots have fired or been squashed so that no slot is selected twice within a block.

## Interface
- NUM_SLOTS, 8: number of reservation-station slots served; power of two, ≥2.
- IDX_W, $clog2(NUM_SLOTS): slot index width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. One clock, asynchronous active-high reset; all state cleared immediately on assertion.
- flush  in  1  synchronous block flush/commit; clears per-block state.
- slot_ready  in  NUM_SLOTS  bit i = slot i holds all operands, including predicate if used.
- slot_pred_valid  in  NUM_SLOTS  bit i = slot i's predicate condition met (1 when unpredicated).
- issue_valid  out  1  issue register holds an instruction for the ALU.
- issue_ready  in  1  ALU accepts this cycle.
- issue_slot  out  IDX_W  slot index being issued.
- squash_valid  out  1  one-cycle pulse: squash_slot was nullified.
- squash_slot  out  IDX_W  index of nullified slot.
- slot_ack  out  NUM_SLOTS  one-hot pulse; tells the RS slot to free its entry.
- done_mask  out  NUM_SLOTS  slots issued-pending, issued, or squashed in the current block.
- busy  out  1  issue_valid | squash_valid.

## Operation
- Slot eligibility:
  - Issue-eligible(i) = slot_ready[i] & slot_pred_valid[i] & !done_mask[i].
  - Squash-eligible(i) = slot_ready[i] & !slot_pred_valid[i] & !done_mask[i].
  - The two are mutually exclusive by construction.
- Issue register load:
  - Load occurs when the register is free: !issue_valid, or issue_valid & issue_ready.
  - Selection is the first issue-eligible slot scanning from rr_ptr upward, wrapping N-1→0.
  - On load: issue_valid←1, issue_slot←sel, done_mask[sel]←1, rr_ptr←(sel+1) mod N.
  - If no eligible slot, issue_valid←0 and rr_ptr is unchanged.
- Stall: while issue_valid & !issue_ready, issue_slot and issue_valid hold. Selection is frozen and rr_ptr does not move.
- Issue ack: slot_ack[issue_slot] pulses in the cycle where issue_valid & issue_ready.
- Predicate is sampled only at selection. If the slot's pred or ready drops after load, the slot still issues.
- Squash path:
  - Each cycle, the lowest-index squash-eligible slot is registered: squash_valid←1, squash_slot←idx, done_mask[idx]←1.
  - In the following cycle, squash_valid is high and slot_ack[squash_slot] pulses.
  - Throughput is one squash per cycle, independent of the issue path.
- slot_ack may carry two bits in one cycle (one issue ack, one squash ack), never on the same slot.
- Flush:
  - Next state: done_mask=0, issue_valid=0, squash_valid=0, rr_ptr=0.
  - A handshake coincident with flush produces no slot_ack.
  - No new selection is made in the flush cycle.
- Reset: as flush, applied asynchronously.

## Timing
- Reset values: issue_valid=0, issue_slot=0, squash_valid=0, squash_slot=0, slot_ack=0, done_mask=0, busy=0, rr_ptr=0.
- Issue latency: slot becomes issue-eligible at cycle t with register free → issue_valid=1 at t+1.
- Issue throughput: one instruction per cycle with issue_ready held high.
- Squash latency: squash-eligible at t → squash_valid and slot_ack pulse at t+1; done_mask bit visible at t+1.
- done_mask for an issued slot is set the cycle issue_valid rises, not at handshake, so it is never reselected while stalled.
- All slots done, or none eligible → issue_valid falls the cycle after the last handshake.
- Wrap: selecting slot N-1 sets rr_ptr=0.

## Test plan
- Reset mid-operation: assert rst while issue_valid=1 → all outputs 0 immediately; after release, slot_ready=8'h01 and pred=8'h01 → issue_valid=1, issue_slot=0 on the next cycle.
- Round-robin with wrap: slot_ready=8'hFF, pred=8'hFF, issue_ready=1 → issue_slot sequence 0..7 on consecutive cycles, then issue_valid=0; done_mask=8'hFF.
- Stall: slot_ready=8'h0C, pred=8'hFF, issue_ready=0 for 3 cycles → issue_slot=2 held stable with no slot_ack. Then issue_ready=1 → slot_ack=8'h04, next issue_slot=3.
- Squash: slot_ready=8'h12, pred=8'h00 → squash_slot=1 then squash_slot=4 on consecutive cycles; slot_ack=8'h02 then 8'h10; issue_valid stays 0.
- Concurrent paths: slot_ready=8'h03, pred=8'h01, issue_ready=1 → in the same cycle issue_slot=0 and squash_slot=1; the handshake cycle shows slot_ack=8'h03.
- Flush during stall: issue_valid=1 with issue_slot=5, then flush=1 with issue_ready=1 → no slot_ack. Next cycle issue_valid=0 and done_mask=0; slot 5 is reselectable afterwards.
